// File: rtl/sram_arbiter.sv
// Request/acknowledge arbiter and strobe sequencer for the shared external SRAM.
// One access at a time: IDLE -> ACCESS (ACC_CYCLES) -> RECOVER (ACK, data hold) -> IDLE.
module sram_arbiter #(
  parameter int NCH        = 3,
  parameter int AW         = 21,
  parameter int DW         = 16,
  parameter int ACC_CYCLES = 2,
  parameter int RR_MODE    = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NCH-1:0]    i_req,
  input  logic [NCH-1:0]    i_we,
  input  logic [NCH*2-1:0]  i_be,
  input  logic [NCH*AW-1:0] i_addr,
  input  logic [NCH*DW-1:0] i_wdata,
  output logic [NCH-1:0]    o_ack,
  output logic [DW-1:0]     o_rdata,
  output logic [2:0]        o_gnt,
  output logic              o_busy,
  output logic [AW-1:0]     o_ma,
  output logic [DW-1:0]     o_md_o,
  output logic              o_md_oe,
  input  logic [DW-1:0]     i_md_i,
  output logic [1:0]        o_mrd_n,
  output logic [1:0]        o_mwr_n
);
  localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
  localparam int HW = DW / 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;
  state_t r_state, w_next;

  logic [CW-1:0]  r_cnt;
  logic           r_we;
  logic [1:0]     r_be;
  logic [2:0]     r_ptr;
  logic [NCH-1:0] r_ack;
  logic [DW-1:0]  r_rdata;
  logic [2:0]     r_gnt;
  logic           r_busy;
  logic [AW-1:0]  r_ma;
  logic [DW-1:0]  r_md_o;
  logic           r_md_oe;
  logic [1:0]     r_mrd_n;
  logic [1:0]     r_mwr_n;

  logic       w_any, w_found, w_we;
  logic [2:0] w_win;
  logic [3:0] w_idx;
  logic [1:0] w_be;
  logic [7:0] w_req8, w_we8;

  assign w_req8 = 8'(i_req);
  assign w_we8  = 8'(i_we);
  assign w_any  = |i_req;

  // Winner search: fixed mode takes the lowest index, RR scans upward from
  // the channel after the last grant and wraps at NCH.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    if (RR_MODE != 0) begin
      for (int i = 1; i <= NCH; i++) begin
        w_idx = 4'(r_ptr) + 4'(i);
        if (w_idx >= 4'(NCH)) w_idx = w_idx - 4'(NCH);
        if (!w_found && w_req8[w_idx[2:0]]) begin
          w_found = 1'b1;
          w_win   = w_idx[2:0];
        end
      end
    end else begin
      for (int i = NCH - 1; i >= 0; i--)
        if (i_req[i]) w_win = 3'(i);
    end
  end

  assign w_we = w_we8[w_win];
  assign w_be = i_be[int'(w_win)*2 +: 2];

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ACCESS;
      ACCESS:  if (r_cnt == '0) w_next = RECOVER;
      RECOVER: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_be    <= 2'b00;
      r_ptr   <= 3'(NCH - 1);
      r_ack   <= '0;
      r_rdata <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_ma    <= '0;
      r_md_o  <= '0;
      r_md_oe <= 1'b0;
      r_mrd_n <= 2'b11;
      r_mwr_n <= 2'b11;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_gnt   <= w_win;
          r_ma    <= i_addr[int'(w_win)*AW +: AW];
          r_md_o  <= i_wdata[int'(w_win)*DW +: DW];
          r_we    <= w_we;
          r_be    <= w_be;
          r_cnt   <= CW'(ACC_CYCLES - 1);
          r_busy  <= 1'b1;
          // Strobes are registered, so they are set on the grant edge.
          r_md_oe <= w_we;
          r_mrd_n <= w_we ? 2'b11 : ~w_be;
          r_mwr_n <= w_we ? ~w_be : 2'b11;
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            r_mrd_n <= 2'b11;
            r_mwr_n <= 2'b11;
            r_ack   <= NCH'(1) << r_gnt;
            if (!r_we) begin
              if (r_be[0]) r_rdata[HW-1:0]  <= i_md_i[HW-1:0];
              if (r_be[1]) r_rdata[DW-1:HW] <= i_md_i[DW-1:HW];
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RECOVER: begin
          // MD_OE was held through this cycle to give write data hold time.
          r_ack   <= '0;
          r_md_oe <= 1'b0;
          r_busy  <= 1'b0;
          r_ptr   <= r_gnt;
        end
        default: ;
      endcase
    end
  end

  assign o_ack   = r_ack;
  assign o_rdata = r_rdata;
  assign o_gnt   = r_gnt;
  assign o_busy  = r_busy;
  assign o_ma    = r_ma;
  assign o_md_o  = r_md_o;
  assign o_md_oe = r_md_oe;
  assign o_mrd_n = r_mrd_n;
  assign o_mwr_n = r_mwr_n;
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Multi-channel arbiter and timing sequencer for the single external 16-bit SRAM that holds internal ROM, cartridge ROM and RAM.
- Replaces the combinational address/strobe/data muxing in the top level with a request/acknowledge scheme.
- Up to NCH masters (MCU ROM/file loader, CPU, future DMA/video fetch) queue requests; one SRAM access is run at a time with programmable strobe length.
- Read data is latched, so masters never sample the live bus.

Parameters:
NCH, 3, number of requesting channels (1..8)
AW, 21, SRAM address width
DW, 16, SRAM data width (two byte lanes, DW/2 bits each)
ACC_CYCLES, 2, CLK cycles strobe is held low per access (>=1)
RR_MODE, 0, 0 = fixed priority (channel 0 highest), 1 = round-robin

Ports:
CLK  in  1  system clock (56 MHz domain)
RESET  in  1  asynchronous active-high reset
REQ  in  NCH  per-channel request level, held until ACK
WE  in  NCH  per-channel 1 = write, 0 = read
BE  in  NCH*2  per-channel byte-lane enables, [1] = high lane
ADDR  in  NCH*AW  per-channel address, channel i at [i*AW +: AW]
WDATA  in  NCH*DW  per-channel write data
ACK  out  NCH  one-cycle completion pulse for granted channel
RDATA  out  DW  latched read data from last completed read
GNT  out  3  index of channel currently owning the bus
BUSY  out  1  1 whenever state is not IDLE
MA  out  AW  SRAM address
MD_O  out  DW  SRAM write data
MD_OE  out  1  drive enable for MD (top level builds the tristate)
MD_I  in  DW  SRAM read data
MRD_N  out  2  per-lane read strobe, active low
MWR_N  out  2  per-lane write strobe, active low

Behaviour:
- Reset (async, immediate, mid-access included):
  - state IDLE; ACK=0; RDATA=0; GNT=0; BUSY=0; MA=0; MD_O=0; MD_OE=0; MRD_N=2'b11; MWR_N=2'b11.
  - Round-robin pointer = NCH-1, so channel 0 wins first.
- States: IDLE, ACCESS, RECOVER.
- IDLE:
  - If any REQ is high, pick winner g. Fixed mode: lowest set index. RR mode: first set index after last grant, wrapping modulo NCH.
  - Register GNT=g, MA=ADDR[g], MD_O=WDATA[g], op=WE[g], lanes=BE[g]; cnt=ACC_CYCLES-1; go ACCESS.
  - REQ bits >= NCH do not exist; no REQ means stay IDLE.
- ACCESS (exactly ACC_CYCLES cycles):
  - Read: MRD_N=~lanes, MWR_N=11, MD_OE=0.
  - Write: MWR_N=~lanes, MRD_N=11, MD_OE=1.
  - MA and MD_O stable throughout.
  - cnt decrements each cycle. At cnt==0, a read captures MD_I into RDATA, merging only enabled lanes; disabled lanes keep their old value. Then go RECOVER.
- RECOVER (1 cycle):
  - All strobes 11; MA held.
  - For a write, MD_OE and MD_O stay held (data hold after strobe release); MD_OE drops on exit.
  - ACK[g]=1 for this cycle only, with RDATA already valid. RR pointer := g. Next state IDLE.
- Latency: REQ first sampled in IDLE at cycle t; strobes at t+1..t+ACC_CYCLES; ACK at t+ACC_CYCLES+1.
- Throughput: one access per ACC_CYCLES+2 cycles. A continuously held REQ is granted again in the IDLE after ACK.
- Requester drops REQ on the clock edge where it sees ACK, so IDLE sees it low.
- REQ changes on non-granted channels during ACCESS/RECOVER are ignored until the next IDLE.
- Deasserting REQ of the granted channel mid-access does not abort; the access completes and ACK still pulses.
- BE=00: full timing runs, strobes stay 11, ACK still issued, RDATA unchanged.
- Arbitration decision is combinational on REQ in IDLE only; all outputs are registered.

Test Plan:
- Fixed, ACC_CYCLES=2: ch1 read ADDR=21'h080123, BE=01, MD_I=16'hxxA5 -> MA=080123, MRD_N=10 for 2 cycles; ACK[1] at t+3; RDATA[7:0]=A5, high byte unchanged.
- Fixed: ch0 write ADDR=21'h100000, WDATA=16'h005A, BE=01 -> MWR_N=10 for 2 cycles; MD_OE=1 in ACCESS and RECOVER with MD_O=005A; MWR_N=11 in RECOVER; ACK[0] at t+3.
- Fixed: REQ=3'b111 held, each channel drops on its ACK -> grant order 0,1,2; ACKs at cycles t+3, t+7, t+11.
- RR_MODE=1: REQ=3'b101 held continuously for 6 accesses -> GNT sequence 0,2,0,2,0,2; ch1 never acked.
- RESET pulse during 2nd ACCESS cycle of a write -> same cycle MWR_N=11, MD_OE=0, ACK=0, BUSY=0; after release, pending REQ[2] alone is granted normally.
- ACC_CYCLES=1, BE=00 read on ch0 -> no strobe low; ACK[0] at t+2; RDATA unchanged from previous value.
